// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder.
// State encoding, opcode values and the derived-size helpers live here.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of slices needed to cover the full operand width.
  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice counter width; never narrower than one bit so NCH==1 still elaborates.
  function automatic int calc_cnt_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: combinational ripple of CHUNK full-adder cells.
// c_msb is the carry into the top bit, used by the parent for signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum;

  // Ripple the carry through each full-adder cell, LSB first.
  always_comb begin
    w_c    = '0;
    w_sum  = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      w_sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum   = w_sum;
  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle.
// start/busy/done handshake; s, co and overflow are registered and change
// only on the edge entering DONE.
// Optional macro SEQ_ADDER_SATURATE_EN clamps s to signed max/min on overflow.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             overflow
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int CW  = calc_cnt_w(NCH);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_final;

  assign w_base = 32'(r_cnt) * 32'(CHUNK);
  assign w_a_sl = r_a[w_base +: CHUNK];
  assign w_b_sl = r_b[w_base +: CHUNK];
  assign w_last = (r_cnt == CW'(NCH - 1));
  assign w_ovf  = w_cout ^ w_cmsb;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (w_a_sl),
    .b     (w_b_sl),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // Merge the current slice into the accumulator so the final slice can be
  // published in the same edge that enters DONE, without an extra cycle.
  always_comb begin
    w_result                   = r_acc;
    w_result[w_base +: CHUNK]  = w_sum;
    w_final                    = w_result;
`ifdef SEQ_ADDER_SATURATE_EN
    if (w_ovf) begin
      w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM and datapath registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= n1;
            r_b     <= (sub == OP_SUB) ? ~n2 : n2;
            r_carry <= sub;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc[w_base +: CHUNK] <= w_sum;
          r_carry                <= w_cout;
          r_cnt                  <= r_cnt + 1'b1;
          if (w_last) begin
            r_s     <= w_final;
            r_co    <= w_cout;
            r_ovf   <= w_ovf;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign s        = r_s;
  assign co       = r_co;
  assign overflow = r_ovf;

endmodule
